// File: rtl/mem_initiator_pkg.sv
// Shared types and constants for the 6-entry x 8-bit register-file initiator.
package mem_initiator_pkg;

  typedef enum logic [1:0] {
    READ  = 2'b00,
    WRITE = 2'b01,
    CLEAR = 2'b10,
    RSVD  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    ISSUE_RD,
    WAIT_RD,
    RESP
  } state_e;

  localparam int        MEM_DEPTH     = 6;
  localparam logic [7:0] MEM_RESET_VAL = 8'hFF;

  function automatic logic cmd_legal(input op_e op, input int addr, input int depth);
    return (op != RSVD) && (addr < depth);
  endfunction

endpackage

// File: rtl/mem_initiator_if.sv
// Host request/response channel plus register-file memory bus for mem_initiator.
interface mem_initiator_if #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_op;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;
  logic              mem_reset1;
  logic              mem_rd_wr1;
  logic [ADDR_W-1:0] mem_addr1;
  logic [DATA_W-1:0] mem_wr_data1;
  logic [DATA_W-1:0] mem_rd_data1;

  modport master (
    input  req_valid, req_op, req_addr, req_wdata, resp_ready, mem_rd_data1,
    output req_ready, resp_valid, resp_rdata, resp_err,
           mem_reset1, mem_rd_wr1, mem_addr1, mem_wr_data1
  );

  modport slave (
    output req_valid, req_op, req_addr, req_wdata, resp_ready, mem_rd_data1,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           mem_reset1, mem_rd_wr1, mem_addr1, mem_wr_data1
  );
endinterface

// File: rtl/mem_initiator.sv
// Single-outstanding-command initiator for the 6x8 register-file memory.
// Optional write read-back check: define MEM_INITIATOR_WRITE_VERIFY_EN.
module mem_initiator
  import mem_initiator_pkg::*;
#(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8,
  parameter int DEPTH  = MEM_DEPTH
) (
  input logic             clk,
  input logic             reset1,
  mem_initiator_if.master bus
);

  state_e            state;
  op_e               op_q;
  op_e               req_op;
  logic              req_ready_q;
  logic              resp_valid_q;
  logic              resp_err_q;
  logic [DATA_W-1:0] resp_rdata_q;
  logic              rd_wr_q;
  logic              clr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  assign req_op = op_e'(bus.req_op);

  assign bus.req_ready    = req_ready_q;
  assign bus.resp_valid   = resp_valid_q;
  assign bus.resp_err     = resp_err_q;
  assign bus.resp_rdata   = resp_rdata_q;
  assign bus.mem_rd_wr1   = rd_wr_q;
  assign bus.mem_addr1    = addr_q;
  assign bus.mem_wr_data1 = wdata_q;
  // Unregistered reset term keeps the memory in reset for exactly as long as we are.
  assign bus.mem_reset1   = reset1 | clr_q;

  always_ff @(posedge clk) begin
    if (reset1) begin
      state        <= IDLE;
      op_q         <= READ;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      rd_wr_q      <= 1'b1;
      clr_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            op_q         <= req_op;
            req_ready_q  <= 1'b0;
            resp_rdata_q <= '0;
            if (cmd_legal(req_op, int'(bus.req_addr), DEPTH)) begin
              state      <= ISSUE;
              resp_err_q <= 1'b0;
              // Memory-side registers are loaded here so they are live during ISSUE.
              case (req_op)
                READ:  addr_q <= bus.req_addr;
                WRITE: begin
                  addr_q  <= bus.req_addr;
                  wdata_q <= bus.req_wdata;
                  rd_wr_q <= 1'b0;
                end
                default: clr_q <= 1'b1;
              endcase
            end else begin
              state        <= RESP;
              resp_err_q   <= 1'b1;
              resp_valid_q <= 1'b1;
            end
          end
        end

        ISSUE: begin
          rd_wr_q <= 1'b1;
          clr_q   <= 1'b0;
          case (op_q)
            READ: state <= WAIT_RD;
`ifdef MEM_INITIATOR_WRITE_VERIFY_EN
            WRITE: state <= ISSUE_RD;
`else
            WRITE: begin
              state        <= RESP;
              resp_valid_q <= 1'b1;
            end
`endif
            default: begin
              state        <= RESP;
              resp_valid_q <= 1'b1;
            end
          endcase
        end

        // Address is still held from the write, so the read-back needs no setup.
        ISSUE_RD: state <= WAIT_RD;

        WAIT_RD: begin
          resp_rdata_q <= bus.mem_rd_data1;
`ifdef MEM_INITIATOR_WRITE_VERIFY_EN
          if (op_q == WRITE) resp_err_q <= (bus.mem_rd_data1 != wdata_q);
`endif
          state        <= RESP;
          resp_valid_q <= 1'b1;
        end

        RESP: begin
          if (bus.resp_ready) begin
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            state        <= IDLE;
          end
        end

        default: begin
          state        <= IDLE;
          req_ready_q  <= 1'b1;
          resp_valid_q <= 1'b0;
          rd_wr_q      <= 1'b1;
          clr_q        <= 1'b0;
        end
      endcase
    end
  end

endmodule
